// File: rtl/cpu_sequencer_pkg.sv
// Shared codes for the multicycle MIPS core: opcodes, function codes, sequencer states.
// Also holds the default halt address and the halt-detection helper.
package cpu_sequencer_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned DATA_W   = 32;

  localparam logic [DATA_W-1:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

  typedef enum logic [OPCODE_W-1:0] {
    OP_SPECIAL = 6'h00,
    OP_ADDIU   = 6'h09,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2b
  } opcode_t;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_JR   = 6'h08,
    FUNC_ADDU = 6'h21
  } func_t;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC1  = 3'd2,
    EXEC2  = 3'd3,
    HALTED = 3'd4
  } state_t;

  // True for a JR whose target is the halt address.
  function automatic logic is_halt_jr(input logic [OPCODE_W-1:0] op,
                                      input logic [FUNC_W-1:0]   fn,
                                      input logic [DATA_W-1:0]   target,
                                      input logic [DATA_W-1:0]   halt_addr);
    return (op == OP_SPECIAL) && (fn == FUNC_JR) && (target == halt_addr);
  endfunction

endpackage

// File: rtl/cpu_perf_counters.sv
// Active-cycle and retired-instruction counters for the sequencer.
// Only built when CPU_PERF_COUNTERS_EN is defined.
`ifdef CPU_PERF_COUNTERS_EN
module cpu_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             freeze_i,
  input  logic             active_i,
  input  logic             retire_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  // Both counters wrap naturally and stop once the core has halted.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    if (!freeze_i) begin
      if (active_i) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (retire_i) retired_cnt_d = retired_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;

endmodule
`endif

// File: rtl/cpu_sequencer.sv
// Multicycle state sequencer: IDLE->FETCH->EXEC1->EXEC2, waitrequest stalls, JR-to-halt.
// Optional performance counters under CPU_PERF_COUNTERS_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [DATA_W-1:0] HALT_ADDR = HALT_ADDR_DEFAULT,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [FUNC_W-1:0]   function_i,
  input  logic [DATA_W-1:0]   rs_data_i,
  input  logic                ram_rd_i,
  input  logic                ram_wr_i,
  input  logic                waitrequest_i,
  output logic [STATE_W-1:0]  state_o,
  output logic                stall_o,
  output logic                instr_done_o,
  output logic                active_o,
  output logic [CNT_W-1:0]    cycle_cnt_o,
  output logic [CNT_W-1:0]    retired_cnt_o
);

  state_t state_q, state_d;
  logic   halt_pending_q, halt_pending_d;
  logic   instr_done_q, instr_done_d;
  logic   active_q, active_d;
  logic   stall_c;
  logic   retire_c;

  // Waitrequest only matters while the decoder is actually touching RAM.
  assign stall_c  = (ram_rd_i | ram_wr_i) & waitrequest_i;
  assign retire_c = (state_q == EXEC2) & ~stall_c;

  always_comb begin
    state_d        = state_q;
    halt_pending_d = halt_pending_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (!stall_c) state_d = EXEC1;
      EXEC1:  if (!stall_c) state_d = EXEC2;
      EXEC2: begin
        if (!stall_c) begin
          state_d = halt_pending_q ? HALTED : FETCH;
          // Pending is sticky: a halting JR in the delay slot keeps it set.
          if (is_halt_jr(opcode_i, function_i, rs_data_i, HALT_ADDR)) halt_pending_d = 1'b1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
    instr_done_d = retire_c;
    active_d     = state_d inside {FETCH, EXEC1, EXEC2};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      halt_pending_q <= 1'b0;
      instr_done_q   <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      halt_pending_q <= halt_pending_d;
      instr_done_q   <= instr_done_d;
      active_q       <= active_d;
    end
  end

  assign state_o      = state_q;
  assign stall_o      = stall_c;
  assign instr_done_o = instr_done_q;
  assign active_o     = active_q;

`ifdef CPU_PERF_COUNTERS_EN
  // Retire count advances on the same edge that raises instr_done_o.
  cpu_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf_counters (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .freeze_i     (state_q == HALTED),
    .active_i     (active_q),
    .retire_i     (retire_c),
    .cycle_cnt_o  (cycle_cnt_o),
    .retired_cnt_o(retired_cnt_o)
  );
`else
  assign cycle_cnt_o   = '0;
  assign retired_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level programs expanded into expected
// per-cycle traces, with directed halt / stall / reset / counter scenarios plus random programs.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic              clk;
  logic              rst_n;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [31:0]       rs_data;
  logic              ram_rd;
  logic              ram_wr;
  logic              waitreq;
  logic [2:0]        state;
  logic              stall;
  logic              instr_done;
  logic              active;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  retired_cnt;

  int total = 0;
  int bad   = 0;

  cpu_sequencer #(
    .HALT_ADDR(32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .opcode_i     (opcode),
    .function_i   (funct),
    .rs_data_i    (rs_data),
    .ram_rd_i     (ram_rd),
    .ram_wr_i     (ram_wr),
    .waitrequest_i(waitreq),
    .state_o      (state),
    .stall_o      (stall),
    .instr_done_o (instr_done),
    .active_o     (active),
    .cycle_cnt_o  (cycle_cnt),
    .retired_cnt_o(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction of a test program: fields plus stall cycles per state.
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    int unsigned s0;
    int unsigned s1;
    int unsigned s2;
    bit          noram;
  } instr_t;

  // One expected clock cycle: inputs to drive and outputs to expect.
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic        rd;
    logic        wr;
    logic        wt;
    logic [2:0]  st;
    logic        stl;
    logic        done;
    logic        act;
    logic [31:0] ccnt;
    logic [31:0] rcnt;
  } cyc_t;

  instr_t prog[$];
  cyc_t   tr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                                input int unsigned s0, input int unsigned s1, input int unsigned s2);
    instr_t t;
    t.op = op; t.fn = fn; t.rs = rs;
    t.s0 = s0; t.s1 = s1; t.s2 = s2;
    t.noram = !((op == OP_LW) || (op == OP_SW));
    return t;
  endfunction

  // Expand the program into a cycle trace: each instruction is F/E1/E2, each stretched by
  // its stall count; the instruction after a JR-to-halt is the last one executed.
  function automatic void build_trace(input int unsigned halted_tail);
    cyc_t        c;
    bit          pending = 1'b0;
    bit          halted  = 1'b0;
    int unsigned n;
    int unsigned act_sum = 0;
    int unsigned ret_sum = 0;
    tr.delete();
    c = '{default: '0};
    c.st = 3'(IDLE);
    tr.push_back(c);
    for (int i = 0; i < prog.size() && !halted; i++) begin
      for (int s = 0; s < 3; s++) begin
        n = (s == 0) ? prog[i].s0 : (s == 1) ? prog[i].s1 : prog[i].s2;
        for (int k = 0; k <= int'(n); k++) begin
          c = '{default: '0};
          c.op = prog[i].op; c.fn = prog[i].fn; c.rs = prog[i].rs;
          c.st = 3'(s + 1);
          if (k < int'(n)) begin
            c.rd = 1'($urandom_range(0, 1));
            c.wr = ~c.rd;
            c.wt = 1'b1;
          end else if (prog[i].noram) begin
            c.wt = 1'($urandom_range(0, 1));
          end else begin
            c.rd = 1'($urandom_range(0, 1));
            c.wr = c.rd ? 1'b0 : 1'b1;
          end
          c.stl = (c.rd | c.wr) & c.wt;
          tr.push_back(c);
        end
      end
      if (pending) halted = 1'b1;
      else if (prog[i].op == OP_SPECIAL && prog[i].fn == FUNC_JR && prog[i].rs == 32'h0) pending = 1'b1;
    end
    if (halted) begin
      for (int k = 0; k < int'(halted_tail); k++) begin
        c = '{default: '0};
        c.st = 3'(HALTED);
        c.rd = 1'($urandom_range(0, 1));
        c.wr = 1'($urandom_range(0, 1));
        c.wt = 1'($urandom_range(0, 1));
        c.op = 6'(OP_SPECIAL); c.fn = 6'(FUNC_JR);
        c.stl = (c.rd | c.wr) & c.wt;
        tr.push_back(c);
      end
    end
    for (int j = 0; j < tr.size(); j++) begin
      tr[j].act  = tr[j].st inside {3'd1, 3'd2, 3'd3};
      tr[j].done = (j > 0) && (tr[j-1].st == 3'd3) && !tr[j-1].stl;
      tr[j].ccnt = act_sum;
      if (tr[j].done) ret_sum++;
      tr[j].rcnt = ret_sum;
      if (tr[j].act) act_sum++;
    end
  endfunction

  task automatic drive_idle();
    opcode = '0; funct = '0; rs_data = '0;
    ram_rd = 1'b0; ram_wr = 1'b0; waitreq = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle 0 starts right after reset release; later cycles start 1 unit after each posedge.
  task automatic run_trace(input int limit);
    for (int j = 0; j < limit && j < tr.size(); j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      opcode = tr[j].op; funct = tr[j].fn; rs_data = tr[j].rs;
      ram_rd = tr[j].rd; ram_wr = tr[j].wr; waitreq = tr[j].wt;
      #1;
      check($sformatf("state[%0d]", j), 32'(state), 32'(tr[j].st));
      check($sformatf("stall[%0d]", j), 32'(stall), 32'(tr[j].stl));
      check($sformatf("done[%0d]", j), 32'(instr_done), 32'(tr[j].done));
      check($sformatf("active[%0d]", j), 32'(active), 32'(tr[j].act));
`ifdef CPU_PERF_COUNTERS_EN
      check($sformatf("cycle_cnt[%0d]", j), 32'(cycle_cnt), tr[j].ccnt);
      check($sformatf("retired_cnt[%0d]", j), 32'(retired_cnt), tr[j].rcnt);
`else
      check($sformatf("cycle_cnt_tied[%0d]", j), 32'(cycle_cnt), 32'h0);
      check($sformatf("retired_cnt_tied[%0d]", j), 32'(retired_cnt), 32'h0);
`endif
    end
  endtask

  function automatic instr_t rand_instr();
    int unsigned pick = $urandom_range(0, 9);
    int unsigned s0 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    int unsigned s1 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
    int unsigned s2 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    case (pick)
      0, 1, 2: return mk(OP_ADDIU, 6'h00, $urandom, s0, 0, 0);
      3:       return mk(OP_SPECIAL, FUNC_ADDU, $urandom, s0, 0, 0);
      4, 5:    return mk(OP_LW, 6'h00, $urandom, s0, s1, s2);
      6:       return mk(OP_SW, 6'h00, $urandom, s0, s1, s2);
      7, 8:    return mk(OP_SPECIAL, FUNC_JR, 32'h0000_0400 | $urandom_range(1, 255), s0, 0, 0);
      default: return mk(OP_SPECIAL, FUNC_JR, 32'h0, s0, 0, 0);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    drive_idle();

    // Plain ADDIU stream, no waitrequest.
    reset_dut();
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(mk(OP_ADDIU, 6'h00, 32'h1234, 0, 0, 0));
    build_trace(0);
    run_trace(tr.size());

    // LW stalled 4 cycles in EXEC1; ADDU with waitrequest but no RAM access.
    reset_dut();
    prog.delete();
    prog.push_back(mk(OP_LW, 6'h00, 32'h10, 0, 4, 0));
    prog.push_back(mk(OP_SPECIAL, FUNC_ADDU, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_SW, 6'h00, 32'h20, 2, 0, 3));
    build_trace(0);
    run_trace(tr.size());

    // Non-halting JR, then JR to halt address with its delay slot, then 100 halted cycles.
    reset_dut();
    prog.delete();
    prog.push_back(mk(OP_SPECIAL, FUNC_JR, 32'h0000_0400, 0, 0, 0));
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_SPECIAL, FUNC_JR, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 2, 0));
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 0, 0));
    build_trace(100);
    run_trace(tr.size());

    // Halting JR sitting in the delay slot of another halting JR.
    reset_dut();
    prog.delete();
    prog.push_back(mk(OP_SPECIAL, FUNC_JR, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_SPECIAL, FUNC_JR, 32'h0, 0, 0, 1));
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 0, 0));
    build_trace(10);
    run_trace(tr.size());

    // Async reset in the middle of a stalled EXEC1 with halt pending.
    reset_dut();
    prog.delete();
    prog.push_back(mk(OP_SPECIAL, FUNC_JR, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_LW, 6'h00, 32'h0, 0, 3, 0));
    build_trace(0);
    run_trace(6);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_state", 32'(state), 32'(IDLE));
    check("mid_reset_active", 32'(active), 32'h0);
    check("mid_reset_done", 32'(instr_done), 32'h0);
    check("mid_reset_cycle_cnt", 32'(cycle_cnt), 32'h0);
    check("mid_reset_retired_cnt", 32'(retired_cnt), 32'h0);
    reset_dut();
    prog.delete();
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 0, 0));
    build_trace(0);
    run_trace(tr.size());

    // Counter scenario: 10 ADDIU with 2 stall cycles, JR to halt, delay slot.
    reset_dut();
    prog.delete();
    for (int i = 0; i < 10; i++)
      prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, (i == 7) ? 1 : 0, (i == 3) ? 1 : 0, 0));
    prog.push_back(mk(OP_SPECIAL, FUNC_JR, 32'h0, 0, 0, 0));
    prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 0, 0));
    build_trace(20);
    run_trace(tr.size());
`ifdef CPU_PERF_COUNTERS_EN
    check("final_retired_cnt", 32'(retired_cnt), 32'd12);
    check("final_cycle_cnt", 32'(cycle_cnt), 32'd38);
`endif
    check("final_state_halted", 32'(state), 32'(HALTED));

    // Random programs, each forced to end with a halting JR and its delay slot.
    for (int p = 0; p < 6; p++) begin
      reset_dut();
      prog.delete();
      for (int i = 0; i < 15; i++) prog.push_back(rand_instr());
      prog.push_back(mk(OP_SPECIAL, FUNC_JR, 32'h0, 0, 0, 0));
      prog.push_back(mk(OP_ADDIU, 6'h00, 32'h0, 0, 1, 0));
      build_trace(12);
      run_trace(tr.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
